// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the hardwired control unit: opcodes, IR field
// positions, sequencer state encoding, opcode classes and control bundle.
package cpu_ctrl_pkg;

  localparam int OPW = 5;  // opcode width
  localparam int RFW = 4;  // register-field width

  // IR field positions: opcode on top, then Ra, Rb, Rc packed below it.
  localparam int OP_MSB = 31;
  localparam int OP_LSB = OP_MSB - OPW + 1;
  localparam int RA_MSB = OP_LSB - 1;
  localparam int RA_LSB = RA_MSB - RFW + 1;
  localparam int RB_MSB = RA_LSB - 1;
  localparam int RB_LSB = RB_MSB - RFW + 1;
  localparam int RC_MSB = RB_LSB - 1;
  localparam int RC_LSB = RC_MSB - RFW + 1;

  localparam logic [OPW-1:0] OP_ADD  = 5'b00011;
  localparam logic [OPW-1:0] OP_SUB  = 5'b00100;
  localparam logic [OPW-1:0] OP_SHR  = 5'b00101;
  localparam logic [OPW-1:0] OP_SHL  = 5'b00110;
  localparam logic [OPW-1:0] OP_ROR  = 5'b00111;
  localparam logic [OPW-1:0] OP_ROL  = 5'b01000;
  localparam logic [OPW-1:0] OP_AND  = 5'b01001;
  localparam logic [OPW-1:0] OP_OR   = 5'b01010;
  localparam logic [OPW-1:0] OP_MUL  = 5'b01110;
  localparam logic [OPW-1:0] OP_DIV  = 5'b01111;
  localparam logic [OPW-1:0] OP_NEG  = 5'b10000;
  localparam logic [OPW-1:0] OP_NOT  = 5'b10001;
  localparam logic [OPW-1:0] OP_NOP  = 5'b11010;
  localparam logic [OPW-1:0] OP_HALT = 5'b11011;

  typedef enum logic [3:0] {
    S_T0   = 4'd0,
    S_T1   = 4'd1,
    S_T2   = 4'd2,
    S_T3   = 4'd3,
    S_T4   = 4'd4,
    S_T5   = 4'd5,
    S_T6   = 4'd6,
    S_HALT = 4'd15
  } state_t;

  typedef enum logic [2:0] {
    CL_ALU3,
    CL_MULDIV,
    CL_UNARY,
    CL_NOP,
    CL_HALT,
    CL_ILLEGAL
  } op_class_t;

  // One bit per datapath control strobe; cleared as a unit each cycle.
  typedef struct packed {
    logic pc_out;
    logic zlow_out;
    logic zhigh_out;
    logic mdr_out;
    logic r_out;
    logic mar_in;
    logic pc_in;
    logic mdr_in;
    logic ir_in;
    logic y_in;
    logic z_in;
    logic r_in;
    logic hi_in;
    logic lo_in;
    logic inc_pc;
    logic read;
    logic gra;
    logic grb;
    logic grc;
  } ctrl_t;

endpackage

// File: rtl/opcode_decoder.sv
// Maps the IR opcode field onto the execute-sequence class it follows.
module opcode_decoder
  import cpu_ctrl_pkg::*;
(
  input  logic [OPW-1:0] opcode,
  output op_class_t      op_class
);

  // Pure lookup: every opcode lands in exactly one class.
  always_comb begin
    unique case (opcode)
      OP_ADD, OP_SUB, OP_SHR, OP_SHL,
      OP_ROR, OP_ROL, OP_AND, OP_OR: op_class = CL_ALU3;
      OP_MUL, OP_DIV:                op_class = CL_MULDIV;
      OP_NEG, OP_NOT:                op_class = CL_UNARY;
      OP_NOP:                        op_class = CL_NOP;
      OP_HALT:                       op_class = CL_HALT;
      default:                       op_class = CL_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired fetch/decode/execute control unit for the datapath. Controls are
// combinational from the state register and the IR opcode; Clear low forces
// every control strobe low in the same cycle so an aborted instruction can
// never write a register.
module control_sequencer
  import cpu_ctrl_pkg::*;
(
  input  logic           Clock,
  input  logic           Clear,
  input  logic [31:0]    IR,
  input  logic           MemReady,
  input  logic           Stop,
  output logic           PCout,
  output logic           Zlowout,
  output logic           Zhighout,
  output logic           MDRout,
  output logic           Rout,
  output logic           MARin,
  output logic           PCin,
  output logic           MDRin,
  output logic           IRin,
  output logic           Yin,
  output logic           Zin,
  output logic           Rin,
  output logic           HIin,
  output logic           LOin,
  output logic           IncPC,
  output logic           Read,
  output logic [OPW-1:0] ALU_op,
  output logic           Gra,
  output logic           Grb,
  output logic           Grc,
  output logic           Run,
  output logic           IllegalOp
);

  state_t         state, state_nxt;
  op_class_t      op_class;
  logic [OPW-1:0] opcode;
  logic           t1_wait;     // set once T1 has already spent a cycle waiting
  logic           illegal_op;
  ctrl_t          ctrl;
  logic [OPW-1:0] alu_op;
  state_t         end_state;   // where the last step of an instruction goes

  // Register fields are consumed downstream through Gra/Grb/Grc.
  logic unused_ir;
  assign unused_ir = ^IR[RA_MSB:0];

  assign opcode = IR[OP_MSB:OP_LSB];

  opcode_decoder u_decoder (
    .opcode   (opcode),
    .op_class (op_class)
  );

  assign end_state = Stop ? S_HALT : S_T0;

  // State, T1 wait tracking and the sticky illegal-opcode flag.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge Clock) begin
    if (!Clear) begin
      state      <= S_T0;
      t1_wait    <= 1'b0;
      illegal_op <= 1'b0;
    end else begin
      state   <= state_nxt;
      t1_wait <= (state == S_T1) && !MemReady;
      if (state == S_T2 && op_class == CL_ILLEGAL) illegal_op <= 1'b1;
    end
  end

  // Next state and per-step control strobes.
  // NOTE: every output of this block gets a default first, so no path through
  // the case can leave a variable unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    ctrl      = '0;
    alu_op    = '0;
    unique case (state)
      S_T0: begin
        ctrl.pc_out = 1'b1;
        ctrl.mar_in = 1'b1;
        ctrl.inc_pc = 1'b1;
        ctrl.z_in   = 1'b1;
        state_nxt   = S_T1;
      end
      S_T1: begin
        ctrl.zlow_out = 1'b1;
        ctrl.pc_in    = !t1_wait;
        ctrl.read     = 1'b1;
        ctrl.mdr_in   = 1'b1;
        if (MemReady) state_nxt = S_T2;
      end
      S_T2: begin
        ctrl.mdr_out = 1'b1;
        ctrl.ir_in   = 1'b1;
        unique case (op_class)
          CL_NOP, CL_ILLEGAL: state_nxt = end_state;
          CL_HALT:            state_nxt = S_HALT;
          default:            state_nxt = S_T3;
        endcase
      end
      S_T3: begin
        state_nxt = S_T4;
        unique case (op_class)
          CL_ALU3: begin
            ctrl.grb  = 1'b1;
            ctrl.r_out = 1'b1;
            ctrl.y_in = 1'b1;
          end
          CL_MULDIV: begin
            ctrl.gra  = 1'b1;
            ctrl.r_out = 1'b1;
            ctrl.y_in = 1'b1;
          end
          CL_UNARY: begin
            ctrl.grb   = 1'b1;
            ctrl.r_out = 1'b1;
            ctrl.z_in  = 1'b1;
            alu_op     = opcode;
          end
          default: state_nxt = S_T0;  // IR changed under us: restart cleanly
        endcase
      end
      S_T4: begin
        unique case (op_class)
          CL_ALU3, CL_MULDIV: begin
            ctrl.grc   = (op_class == CL_ALU3);
            ctrl.grb   = (op_class == CL_MULDIV);
            ctrl.r_out = 1'b1;
            ctrl.z_in  = 1'b1;
            alu_op     = opcode;
            state_nxt  = S_T5;
          end
          CL_UNARY: begin
            ctrl.zlow_out = 1'b1;
            ctrl.gra      = 1'b1;
            ctrl.r_in     = 1'b1;
            state_nxt     = end_state;
          end
          default: state_nxt = S_T0;
        endcase
      end
      S_T5: begin
        unique case (op_class)
          CL_ALU3: begin
            ctrl.zlow_out = 1'b1;
            ctrl.gra      = 1'b1;
            ctrl.r_in     = 1'b1;
            state_nxt     = end_state;
          end
          CL_MULDIV: begin
            ctrl.zlow_out = 1'b1;
            ctrl.lo_in    = 1'b1;
            state_nxt     = S_T6;
          end
          default: state_nxt = S_T0;
        endcase
      end
      S_T6: begin
        ctrl.zhigh_out = 1'b1;
        ctrl.hi_in     = 1'b1;
        state_nxt      = end_state;
      end
      S_HALT:  state_nxt = S_HALT;
      default: state_nxt = S_T0;
    endcase
    if (!Clear) begin
      ctrl   = '0;
      alu_op = '0;
    end
  end

  assign PCout     = ctrl.pc_out;
  assign Zlowout   = ctrl.zlow_out;
  assign Zhighout  = ctrl.zhigh_out;
  assign MDRout    = ctrl.mdr_out;
  assign Rout      = ctrl.r_out;
  assign MARin     = ctrl.mar_in;
  assign PCin      = ctrl.pc_in;
  assign MDRin     = ctrl.mdr_in;
  assign IRin      = ctrl.ir_in;
  assign Yin       = ctrl.y_in;
  assign Zin       = ctrl.z_in;
  assign Rin       = ctrl.r_in;
  assign HIin      = ctrl.hi_in;
  assign LOin      = ctrl.lo_in;
  assign IncPC     = ctrl.inc_pc;
  assign Read      = ctrl.read;
  assign Gra       = ctrl.gra;
  assign Grb       = ctrl.grb;
  assign Grc       = ctrl.grc;
  assign ALU_op    = alu_op;
  assign Run       = Clear && (state != S_HALT);
  assign IllegalOp = illegal_op;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: walks hand-computed step tables for
// each instruction class, memory waits, Stop, Clear abort and HALT.
module tb_control_sequencer;

  logic        Clock = 1'b0;
  logic        Clear;
  logic [31:0] IR;
  logic        MemReady;
  logic        Stop;
  logic PCout, Zlowout, Zhighout, MDRout, Rout, MARin, PCin, MDRin, IRin;
  logic Yin, Zin, Rin, HIin, LOin, IncPC, Read, Gra, Grb, Grc, Run, IllegalOp;
  logic [4:0]  ALU_op;

  int n_total = 0;
  int n_bad   = 0;

  // Control bit positions in the packed observation vector below.
  localparam logic [18:0] K_PCOUT  = 19'd1 << 18;
  localparam logic [18:0] K_ZLOW   = 19'd1 << 17;
  localparam logic [18:0] K_ZHIGH  = 19'd1 << 16;
  localparam logic [18:0] K_MDROUT = 19'd1 << 15;
  localparam logic [18:0] K_ROUT   = 19'd1 << 14;
  localparam logic [18:0] K_MARIN  = 19'd1 << 13;
  localparam logic [18:0] K_PCIN   = 19'd1 << 12;
  localparam logic [18:0] K_MDRIN  = 19'd1 << 11;
  localparam logic [18:0] K_IRIN   = 19'd1 << 10;
  localparam logic [18:0] K_YIN    = 19'd1 << 9;
  localparam logic [18:0] K_ZIN    = 19'd1 << 8;
  localparam logic [18:0] K_RIN    = 19'd1 << 7;
  localparam logic [18:0] K_HIIN   = 19'd1 << 6;
  localparam logic [18:0] K_LOIN   = 19'd1 << 5;
  localparam logic [18:0] K_INCPC  = 19'd1 << 4;
  localparam logic [18:0] K_READ   = 19'd1 << 3;
  localparam logic [18:0] K_GRA    = 19'd1 << 2;
  localparam logic [18:0] K_GRB    = 19'd1 << 1;
  localparam logic [18:0] K_GRC    = 19'd1 << 0;

  localparam logic [18:0] E_T0  = K_PCOUT | K_MARIN | K_INCPC | K_ZIN;
  localparam logic [18:0] E_T1F = K_ZLOW | K_PCIN | K_READ | K_MDRIN;
  localparam logic [18:0] E_T1W = K_ZLOW | K_READ | K_MDRIN;
  localparam logic [18:0] E_T2  = K_MDROUT | K_IRIN;
  localparam logic [18:0] E_OFF = 19'd0;

  localparam logic [31:0] IR_AND  = 32'h4A92_0000;  // opcode 01001
  localparam logic [31:0] IR_ADD  = 32'h1812_8000;  // opcode 00011
  localparam logic [31:0] IR_OR   = 32'h5012_8000;  // opcode 01010
  localparam logic [31:0] IR_MUL  = 32'h7090_0000;  // opcode 01110
  localparam logic [31:0] IR_NEG  = 32'h8090_0000;  // opcode 10000
  localparam logic [31:0] IR_NOP  = 32'hD000_0000;  // opcode 11010
  localparam logic [31:0] IR_HALT = 32'hD800_0000;  // opcode 11011
  localparam logic [31:0] IR_BAD  = 32'hF800_0000;  // opcode 11111

  logic [18:0] ctl;
  assign ctl = {PCout, Zlowout, Zhighout, MDRout, Rout, MARin, PCin, MDRin,
                IRin, Yin, Zin, Rin, HIin, LOin, IncPC, Read, Gra, Grb, Grc};

  control_sequencer dut (
    .Clock(Clock), .Clear(Clear), .IR(IR), .MemReady(MemReady), .Stop(Stop),
    .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout), .MDRout(MDRout),
    .Rout(Rout), .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin),
    .Yin(Yin), .Zin(Zin), .Rin(Rin), .HIin(HIin), .LOin(LOin),
    .IncPC(IncPC), .Read(Read), .ALU_op(ALU_op), .Gra(Gra), .Grb(Grb),
    .Grc(Grc), .Run(Run), .IllegalOp(IllegalOp)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One step's worth of comparisons, including the single-bus-driver rule.
  task automatic expect_step(input string tag, input logic [18:0] c,
                             input logic [4:0] a, input logic r);
    check({tag, ".ctl"}, 32'(ctl), 32'(c));
    check({tag, ".alu"}, 32'(ALU_op), 32'(a));
    check({tag, ".run"}, 32'(Run), 32'(r));
    check({tag, ".bus"},
          32'($countones({PCout, Zlowout, Zhighout, MDRout, Rout}) <= 1), 32'd1);
  endtask

  task automatic advance();
    @(posedge Clock);
    #1;
  endtask

  // Enter after advancing into T0; leaves just after the edge ending T2.
  task automatic fetch(input string tag, input logic [31:0] ir, input int waits);
    MemReady = (waits == 0);
    #1;
    expect_step({tag, ".t0"}, E_T0, 5'd0, 1'b1);
    for (int k = 0; k <= waits; k++) begin
      advance();
      MemReady = (k == waits);
      #1;
      expect_step({tag, ".t1"}, (k == 0) ? E_T1F : E_T1W, 5'd0, 1'b1);
    end
    advance();
    IR = ir;
    #1;
    expect_step({tag, ".t2"}, E_T2, 5'd0, 1'b1);
    advance();
  endtask

  initial begin
    Clear = 1'b0; IR = 32'd0; MemReady = 1'b1; Stop = 1'b0;
    #1;
    expect_step("rst_low", E_OFF, 5'd0, 1'b0);
    check("rst_illegal", 32'(IllegalOp), 32'd0);
    advance();
    Clear = 1'b1;

    // AND: 6 cycles, T0 again on cycle 7
    fetch("and", IR_AND, 0);
    #1; expect_step("and.t3", K_GRB | K_ROUT | K_YIN, 5'd0, 1'b1);
    advance(); #1; expect_step("and.t4", K_GRC | K_ROUT | K_ZIN, 5'b01001, 1'b1);
    advance(); #1; expect_step("and.t5", K_ZLOW | K_GRA | K_RIN, 5'd0, 1'b1);
    advance();

    // ADD with a 3-cycle memory wait: 9 cycles
    fetch("addw", IR_ADD, 3);
    #1; expect_step("addw.t3", K_GRB | K_ROUT | K_YIN, 5'd0, 1'b1);
    advance(); #1; expect_step("addw.t4", K_GRC | K_ROUT | K_ZIN, 5'b00011, 1'b1);
    advance(); #1; expect_step("addw.t5", K_ZLOW | K_GRA | K_RIN, 5'd0, 1'b1);
    advance();

    // MUL: 7 cycles, LO then HI
    fetch("mul", IR_MUL, 0);
    #1; expect_step("mul.t3", K_GRA | K_ROUT | K_YIN, 5'd0, 1'b1);
    advance(); #1; expect_step("mul.t4", K_GRB | K_ROUT | K_ZIN, 5'b01110, 1'b1);
    advance(); #1; expect_step("mul.t5", K_ZLOW | K_LOIN, 5'd0, 1'b1);
    advance(); #1; expect_step("mul.t6", K_ZHIGH | K_HIIN, 5'd0, 1'b1);
    advance();

    // NEG: 5 cycles
    fetch("neg", IR_NEG, 0);
    #1; expect_step("neg.t3", K_GRB | K_ROUT | K_ZIN, 5'b10000, 1'b1);
    advance(); #1; expect_step("neg.t4", K_ZLOW | K_GRA | K_RIN, 5'd0, 1'b1);
    advance();

    // NOP: straight back to fetch after T2
    fetch("nop", IR_NOP, 0);

    // Illegal opcode behaves as NOP and sets the sticky flag
    fetch("bad", IR_BAD, 0);
    check("bad.flag_set", 32'(IllegalOp), 32'd1);
    fetch("sticky", IR_ADD, 0);
    #1; expect_step("sticky.t3", K_GRB | K_ROUT | K_YIN, 5'd0, 1'b1);
    advance(); #1; expect_step("sticky.t4", K_GRC | K_ROUT | K_ZIN, 5'b00011, 1'b1);
    advance(); #1; expect_step("sticky.t5", K_ZLOW | K_GRA | K_RIN, 5'd0, 1'b1);
    check("sticky.flag", 32'(IllegalOp), 32'd1);
    advance();

    // Stop raised in T3 of ADD: finish the ADD, then HALT
    fetch("stop", IR_ADD, 0);
    Stop = 1'b1;
    #1; expect_step("stop.t3", K_GRB | K_ROUT | K_YIN, 5'd0, 1'b1);
    advance(); #1; expect_step("stop.t4", K_GRC | K_ROUT | K_ZIN, 5'b00011, 1'b1);
    advance(); #1; expect_step("stop.t5", K_ZLOW | K_GRA | K_RIN, 5'd0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      advance(); #1; expect_step("stop.halt", E_OFF, 5'd0, 1'b0);
    end
    // Clear together with Stop still high: Clear wins, flag drops
    Clear = 1'b0;
    #1; expect_step("stop.clr", E_OFF, 5'd0, 1'b0);
    advance();
    check("clr.flag", 32'(IllegalOp), 32'd0);
    Clear = 1'b1; Stop = 1'b0;

    // Clear during T4 of OR aborts it: no Rin ever appears for it
    fetch("or", IR_OR, 0);
    #1; expect_step("or.t3", K_GRB | K_ROUT | K_YIN, 5'd0, 1'b1);
    advance();
    Clear = 1'b0;
    #1; expect_step("or.t4clr", E_OFF, 5'd0, 1'b0);
    advance(); #1; expect_step("or.t0clr", E_OFF, 5'd0, 1'b0);
    advance();
    Clear = 1'b1;
    fetch("after_or", IR_NOP, 0);

    // HALT opcode stops sequencing until Clear
    fetch("halt", IR_HALT, 0);
    #1; expect_step("halt.h0", E_OFF, 5'd0, 1'b0);
    advance(); #1; expect_step("halt.h1", E_OFF, 5'd0, 1'b0);
    Clear = 1'b0;
    advance();
    Clear = 1'b1;
    #1; expect_step("halt.rst", E_T0, 5'd0, 1'b1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
